// File: rtl/stepdown_pkg.sv
// rtl/stepdown_pkg.sv - shared state encoding and default constants for the stepdown core-state sequencer
// Contents: state_e (OFF=0, SOFTSTART=1, RUN=2, FAULT=3), default PERIOD_W/PERIOD/DMAX/RETRY_CYC,
//           drives_hs() helper telling which states may command the high side.
package stepdown_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_SOFTSTART = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_e;

  localparam int PERIOD_W  = 8;
  localparam int PERIOD    = 200;
  localparam int DMAX      = 180;
  localparam int RETRY_CYC = 1024;

  // Only the switching states are allowed to turn the high side on.
  function automatic logic drives_hs(state_e s);
    return (s == ST_SOFTSTART) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/stepdown_corestate_seq_if.sv
// rtl/stepdown_corestate_seq_if.sv - control/status bundle between the converter controller and the sequencer
// Signals: en, ocp, duty_tgt (controller -> sequencer); hs_on, pgood, fault, state (sequencer -> controller).
// Modports: master = controller / bench side, slave = sequencer side.
interface stepdown_corestate_seq_if
  import stepdown_pkg::*;
#(
  parameter int PERIOD_W = stepdown_pkg::PERIOD_W
) ();

  logic                en;
  logic                ocp;
  logic [PERIOD_W-1:0] duty_tgt;
  logic                hs_on;
  logic                pgood;
  logic                fault;
  state_e              state;

  modport master (
    output en, ocp, duty_tgt,
    input  hs_on, pgood, fault, state
  );

  modport slave (
    input  en, ocp, duty_tgt,
    output hs_on, pgood, fault, state
  );

endinterface

// File: rtl/stepdown_sync2.sv
// rtl/stepdown_sync2.sv - two-flop synchroniser with asynchronous active-low reset
// Ports: clk_i clock, rst_ni async active-low reset, d_i asynchronous input, q_o synchronised output.
module stepdown_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/stepdown_corestate_seq.sv
// rtl/stepdown_corestate_seq.sv - core-state sequencer: fixed-period PWM, soft-start ramp, OCP fault, power-good
// Ports: CELCLK clock, CELRSTN async active-low reset, CELV/CELG/SUB power and substrate pins (no logic),
//        bus (slave): en, ocp (async), duty_tgt in; hs_on, pgood, fault, state out (all registered).
// Optional: define STEPDOWN_OCP_RETRY_EN to leave FAULT automatically after RETRY_CYC cycles once ocp clears;
//           otherwise FAULT is latched until en drops.
module stepdown_corestate_seq
  import stepdown_pkg::*;
#(
  parameter int PERIOD_W  = stepdown_pkg::PERIOD_W,
  parameter int PERIOD    = stepdown_pkg::PERIOD,
  parameter int DMAX      = stepdown_pkg::DMAX,
  parameter int RETRY_CYC = stepdown_pkg::RETRY_CYC
) (
  input  logic                   CELCLK,
  input  logic                   CELRSTN,
  input  logic                   CELV,
  input  logic                   CELG,
  input  logic                   SUB,
  stepdown_corestate_seq_if.slave bus
);

  localparam logic [PERIOD_W-1:0] CNT_LAST = PERIOD_W'(PERIOD - 1);
  localparam logic [PERIOD_W-1:0] DUTY_MAX = PERIOD_W'(DMAX);

  // Power pins only exist so the brick netlist connects; they carry no logic.
  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ SUB;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] duty_q, duty_d;
  logic                hs_on_q, pgood_q, fault_q;
  logic                ocp_s;
  logic [PERIOD_W-1:0] tgt_c;
  logic                wrap;

`ifdef STEPDOWN_OCP_RETRY_EN
  localparam int             RT_W       = (RETRY_CYC > 2) ? $clog2(RETRY_CYC) : 1;
  localparam logic [RT_W-1:0] RETRY_LAST = RT_W'(RETRY_CYC - 1);
  logic [RT_W-1:0] retry_q, retry_d;
`else
  localparam int unused_retry_cyc = RETRY_CYC;
`endif

  stepdown_sync2 u_ocp_sync (
    .clk_i  (CELCLK),
    .rst_ni (CELRSTN),
    .d_i    (bus.ocp),
    .q_o    (ocp_s)
  );

  assign tgt_c = (bus.duty_tgt > DUTY_MAX) ? DUTY_MAX : bus.duty_tgt;
  assign wrap  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    cnt_d   = wrap ? '0 : cnt_q + PERIOD_W'(1);
`ifdef STEPDOWN_OCP_RETRY_EN
    retry_d = retry_q;
`endif
    if (!bus.en) begin
      // Disable wins over everything, including a coincident over-current.
      state_d = ST_OFF;
      duty_d  = '0;
    end else if (ocp_s && drives_hs(state_q)) begin
      state_d = ST_FAULT;
      duty_d  = '0;
`ifdef STEPDOWN_OCP_RETRY_EN
      retry_d = RETRY_LAST;
`endif
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_SOFTSTART;
          duty_d  = '0;
        end
        ST_SOFTSTART: begin
          // Ramp one cycle per period; a target lowered below the ramp snaps straight to RUN.
          if (wrap) begin
            if (duty_q < tgt_c) begin
              duty_d = duty_q + PERIOD_W'(1);
            end else begin
              duty_d  = tgt_c;
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Duty is only reloaded at a period boundary so a pulse is never truncated or stretched.
          if (wrap) begin
            duty_d = tgt_c;
          end
        end
        ST_FAULT: begin
`ifdef STEPDOWN_OCP_RETRY_EN
          if (retry_q == '0) begin
            if (ocp_s) begin
              retry_d = RETRY_LAST;
            end else begin
              state_d = ST_SOFTSTART;
              duty_d  = '0;
            end
          end else begin
            retry_d = retry_q - RT_W'(1);
          end
`endif
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
    if ((state_d == ST_OFF) || (state_d == ST_FAULT) ||
        ((state_d == ST_SOFTSTART) && (state_q != ST_SOFTSTART))) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      duty_q  <= '0;
      hs_on_q <= 1'b0;
      pgood_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      hs_on_q <= drives_hs(state_d) && (cnt_d < duty_d);
      pgood_q <= (state_d == ST_RUN);
      fault_q <= (state_d == ST_FAULT);
    end
  end

`ifdef STEPDOWN_OCP_RETRY_EN
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign bus.hs_on = hs_on_q;
  assign bus.pgood = pgood_q;
  assign bus.fault = fault_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_stepdown_corestate_seq.sv
// tb/tb_stepdown_corestate_seq.sv - self-checking bench for stepdown_corestate_seq
module tb_stepdown_corestate_seq;

  localparam int PER   = 200;
  localparam int DMX   = 180;
  localparam int RETRY = 1024;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stepdown_corestate_seq_if #(.PERIOD_W(8)) bus ();

  stepdown_corestate_seq dut (
    .CELCLK  (clk),
    .CELRSTN (rst_n),
    .CELV    (1'b1),
    .CELG    (1'b0),
    .SUB     (1'b0),
    .bus     (bus)
  );

  int vectors;
  int miscompares;
  int k_per;
  int cur_t;
  int exp_duty;

  // Reference rules: clamp, per-period pulse width during soft start, pgood timing.
  function automatic int clamp(input int t);
    return (t > DMX) ? DMX : t;
  endfunction

  function automatic int exp_width(input int k, input int t);
    return ((k - 1) < clamp(t)) ? (k - 1) : clamp(t);
  endfunction

  function automatic logic exp_pgood(input int n, input int t);
    return (n >= PER * (clamp(t) + 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output int waited);
    waited = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.state === s) begin
        waited = i;
        return;
      end
    end
  endtask

  // Observes one full period starting at the current sample; optionally changes duty_tgt mid-period.
  task automatic measure(input int chg_at, input int chg_val,
                         output int width, output int first_hi, output int pg_bad);
    width = 0; first_hi = -1; pg_bad = 0;
    for (int i = 0; i < PER; i++) begin
      if (bus.hs_on === 1'b1) begin
        width++;
        if (first_hi < 0) first_hi = i;
      end
      if (bus.pgood !== exp_pgood(PER * (k_per - 1) + i, cur_t)) pg_bad++;
      if (i == chg_at) bus.duty_tgt = 8'(chg_val);
      step();
    end
    k_per++;
  endtask

  task automatic test_reset();
    bus.en = 1'b1;
    repeat (3) step();
    vectors++; if (bus.state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", bus.state); end
    vectors++; if (bus.hs_on !== 1'b0) begin miscompares++; $display("FAIL reset_hs_on got %b exp 0", bus.hs_on); end
    vectors++; if (bus.pgood !== 1'b0) begin miscompares++; $display("FAIL reset_pgood got %b exp 0", bus.pgood); end
    vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b exp 0", bus.fault); end
    bus.en = 1'b0;
    rst_n  = 1'b1;
    step();
    vectors++; if (bus.state !== 2'd0) begin miscompares++; $display("FAIL reset_release_state got %0d exp 0", bus.state); end
  endtask

  task automatic test_softstart(input int t, input int np);
    int w, fh, pb, waited;
    bus.en = 1'b0;
    step();
    vectors++; if (bus.state !== 2'd0) begin miscompares++; $display("FAIL ss_off_state got %0d exp 0", bus.state); end
    bus.duty_tgt = 8'(t);
    bus.en = 1'b1;
    cur_t = t;
    k_per = 1;
    wait_state(2'd1, 5, waited);
    vectors++;
    if (waited < 0) begin
      miscompares++; $display("FAIL ss_entry state got %0d exp 1 (timeout)", bus.state);
      return;
    end
    for (int k = 1; k <= np; k++) begin
      measure(-1, 0, w, fh, pb);
      vectors++; if (w !== exp_width(k, t)) begin miscompares++; $display("FAIL ss_width T=%0d k=%0d got %0d exp %0d", t, k, w, exp_width(k, t)); end
      vectors++; if (fh !== ((exp_width(k, t) > 0) ? 0 : -1)) begin miscompares++; $display("FAIL ss_phase T=%0d k=%0d first_hi got %0d", t, k, fh); end
      vectors++; if (pb !== 0) begin miscompares++; $display("FAIL ss_pgood T=%0d k=%0d wrong_cycles got %0d exp 0", t, k, pb); end
    end
    exp_duty = clamp(t);
  endtask

  task automatic test_clamp();
    int w, fh, pb, v, at;
    v  = $urandom_range(181, 255);
    at = $urandom_range(10, 150);
    measure(at, v, w, fh, pb);
    vectors++; if (w !== exp_duty) begin miscompares++; $display("FAIL clamp_midchange_hold got %0d exp %0d", w, exp_duty); end
    exp_duty = clamp(v);
    measure(-1, 0, w, fh, pb);
    vectors++; if (w !== exp_duty) begin miscompares++; $display("FAIL clamp_width tgt=%0d got %0d exp %0d", v, w, exp_duty); end
    vectors++; if (fh !== 0) begin miscompares++; $display("FAIL clamp_phase got %0d exp 0", fh); end
    v  = $urandom_range(1, 179);
    at = $urandom_range(10, 150);
    measure(at, v, w, fh, pb);
    vectors++; if (w !== exp_duty) begin miscompares++; $display("FAIL lower_midchange_hold got %0d exp %0d", w, exp_duty); end
    exp_duty = clamp(v);
    measure(-1, 0, w, fh, pb);
    vectors++; if (w !== exp_duty) begin miscompares++; $display("FAIL lower_width got %0d exp %0d", w, exp_duty); end
    vectors++; if (pb !== 0) begin miscompares++; $display("FAIL run_pgood wrong_cycles got %0d exp 0", pb); end
  endtask

  task automatic test_ocp();
    int n, bad;
    repeat ($urandom_range(0, 40)) step();
    bus.ocp = 1'b1;
    n = 0;
    while (bus.fault !== 1'b1 && n < 6) begin
      step();
      n++;
    end
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL ocp_latency got %0d cycles exp 3", n); end
    vectors++; if (bus.hs_on !== 1'b0) begin miscompares++; $display("FAIL ocp_hs_on got %b exp 0", bus.hs_on); end
    vectors++; if (bus.state !== 2'd3) begin miscompares++; $display("FAIL ocp_state got %0d exp 3", bus.state); end
    vectors++; if (bus.pgood !== 1'b0) begin miscompares++; $display("FAIL ocp_pgood got %b exp 0", bus.pgood); end
    bus.ocp = 1'b0;
    bad = 0;
`ifdef STEPDOWN_OCP_RETRY_EN
    for (int i = 1; i <= RETRY; i++) begin
      step();
      if (bus.state !== ((i < RETRY) ? 2'd3 : 2'd1)) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL ocp_retry wrong_cycles got %0d exp 0", bad); end
    vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL ocp_retry_fault got %b exp 0", bus.fault); end
`else
    for (int i = 0; i < RETRY + 80; i++) begin
      step();
      if (bus.state !== 2'd3 || bus.fault !== 1'b1 || bus.hs_on !== 1'b0 || bus.pgood !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL ocp_latched wrong_cycles got %0d exp 0", bad); end
    bus.en = 1'b0;
    step();
    vectors++; if (bus.state !== 2'd0 || bus.fault !== 1'b0) begin miscompares++; $display("FAIL ocp_clear state=%0d fault=%b exp 0/0", bus.state, bus.fault); end
`endif
  endtask

`ifdef STEPDOWN_OCP_RETRY_EN
  task automatic test_ocp_hold();
    int n, bad;
    bus.ocp = 1'b1;
    n = 0;
    while (bus.fault !== 1'b1 && n < 6) begin
      step();
      n++;
    end
    vectors++; if (bus.fault !== 1'b1) begin miscompares++; $display("FAIL hold_entry fault got %b exp 1", bus.fault); end
    bad = 0;
    for (int i = 1; i <= 3 * RETRY; i++) begin
      step();
      if (bus.state !== ((i < 3 * RETRY) ? 2'd3 : 2'd1)) bad++;
      if (i == 3000) bus.ocp = 1'b0;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL hold_retry wrong_cycles got %0d exp 0", bad); end
  endtask
`endif

  task automatic test_en_ocp();
    int bad;
    test_softstart(1, 3);
    bus.ocp = 1'b1;
    step();
    step();
    vectors++; if (bus.state !== 2'd2) begin miscompares++; $display("FAIL coinc_pre state got %0d exp 2", bus.state); end
    bus.en = 1'b0;
    step();
    vectors++;
    if (bus.state !== 2'd0 || bus.fault !== 1'b0 || bus.hs_on !== 1'b0 || bus.pgood !== 1'b0) begin
      miscompares++;
      $display("FAIL coinc_off state=%0d fault=%b hs_on=%b pgood=%b exp 0/0/0/0", bus.state, bus.fault, bus.hs_on, bus.pgood);
    end
    bus.ocp = 1'b0;
    bad = 0;
    repeat (5) begin
      step();
      if (bus.state !== 2'd0 || bus.fault !== 1'b0 || bus.hs_on !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL coinc_stay wrong_cycles got %0d exp 0", bad); end
  endtask

  task automatic test_en_mid_softstart();
    int t, waited;
    t = $urandom_range(20, 60);
    bus.en = 1'b0;
    step();
    bus.duty_tgt = 8'(t);
    bus.en = 1'b1;
    wait_state(2'd1, 5, waited);
    vectors++; if (waited < 0) begin miscompares++; $display("FAIL mid_entry state got %0d exp 1 (timeout)", bus.state); end
    repeat ($urandom_range(250, 700)) step();
    vectors++; if (bus.state !== 2'd1) begin miscompares++; $display("FAIL mid_ramp state got %0d exp 1", bus.state); end
    bus.en = 1'b0;
    step();
    vectors++;
    if (bus.state !== 2'd0 || bus.hs_on !== 1'b0 || bus.pgood !== 1'b0 || bus.fault !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_off state=%0d hs_on=%b pgood=%b fault=%b exp 0/0/0/0", bus.state, bus.hs_on, bus.pgood, bus.fault);
    end
    test_softstart($urandom_range(2, 4), 3);
  endtask

  task automatic test_reset_async();
    test_softstart(2, 4);
    vectors++; if (bus.hs_on !== 1'b1) begin miscompares++; $display("FAIL areset_pre hs_on got %b exp 1", bus.hs_on); end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.state !== 2'd0 || bus.hs_on !== 1'b0 || bus.pgood !== 1'b0 || bus.fault !== 1'b0) begin
      miscompares++;
      $display("FAIL areset state=%0d hs_on=%b pgood=%b fault=%b exp 0/0/0/0", bus.state, bus.hs_on, bus.pgood, bus.fault);
    end
    step();
    rst_n = 1'b1;
    step();
    vectors++; if (bus.state !== 2'd1) begin miscompares++; $display("FAIL areset_resume state got %0d exp 1", bus.state); end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    k_per        = 1;
    cur_t        = 0;
    exp_duty     = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.ocp      = 1'b0;
    bus.duty_tgt = 8'd0;
    test_reset();
    test_softstart(3, 6);
    test_clamp();
    test_ocp();
`ifdef STEPDOWN_OCP_RETRY_EN
    test_ocp_hold();
`endif
    test_en_ocp();
    test_en_mid_softstart();
    test_softstart(0, 3);
    test_reset_async();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stepdown_corestate_seq.md
Name: stepdown_corestate_seq

Overview:
- Digital core-state sequencer for the stepdown converter.
- Produces the registered high-side on command `hs_on`, which drives the downstream 5V inverter brick; that brick makes the complementary low-side drive.
- Implements fixed-period PWM, a soft-start duty ramp, an over-current fault state and a power-good flag.

Parameters:
- PERIOD_W, 8, width of the period counter and duty registers.
- PERIOD, 200, PWM period in clock cycles; range 2..2^PERIOD_W.
- DMAX, 180, maximum duty in cycles; must be less than PERIOD.
- RETRY_CYC, 1024, fault hold time in cycles (used only with the optional feature).

Ports:
- CELCLK  input  1  core clock.
- CELRSTN  input  1  asynchronous active-low reset.
- CELV  input  1  core supply (brick power pin, no logic function).
- CELG  input  1  core ground (brick power pin, no logic function).
- SUB  input  1  substrate tie (no logic function).
- en  input  1  converter enable; level-sensitive, synchronous to CELCLK.
- ocp  input  1  over-current comparator; asynchronous to CELCLK.
- duty_tgt  input  PERIOD_W  target duty in cycles.
- hs_on  output  1  high-side on command, feeds the inverter.
- pgood  output  1  high while state is RUN.
- fault  output  1  high while state is FAULT.
- state  output  2  OFF=0, SOFTSTART=1, RUN=2, FAULT=3.

Behaviour:
- Reset, asynchronous on CELRSTN low:
  - state=OFF; period counter cnt=0; duty=0.
  - hs_on=0, pgood=0, fault=0; sync flops=0; retry timer=0.
- ocp passes through a 2-flop synchroniser to give ocp_s (2-cycle latency).
- tgt_c = min(duty_tgt, DMAX).
- cnt counts 0..PERIOD-1 and wraps to 0. A wrap event is a cycle with cnt==PERIOD-1.
- cnt is forced to 0 in OFF and FAULT, and on entry to SOFTSTART.
- hs_on is registered: next hs_on = (state_next is SOFTSTART or RUN) and (cnt_next < duty).
  - duty=0 means hs_on is never high.
  - hs_on is never high in OFF or FAULT.
- State transitions, evaluated in priority order each edge:
  1. en=0 → OFF from any state; duty=0 at the same edge.
  2. ocp_s=1 while in SOFTSTART or RUN → FAULT; hs_on=0 at the same edge; duty=0.
  3. OFF with en=1 → SOFTSTART; duty=0, cnt=0.
  4. SOFTSTART at a wrap event:
     - if duty < tgt_c, duty increments by 1;
     - if duty == tgt_c, go to RUN;
     - if duty > tgt_c (target lowered), load duty=tgt_c and go to RUN.
  5. RUN at a wrap event: duty loads tgt_c. duty never changes mid-period.
  6. FAULT: behaviour depends on the optional feature.
- pgood and fault are registered decodes of the next state; they change on the same edge as `state`.
- Simultaneous events:
  - en falling and ocp_s rising in the same cycle → OFF, and fault=0.
  - Target change mid-period takes effect only at the next wrap event.
- Soft-start duration to target T: T wrap events after SOFTSTART entry, then RUN at the (T+1)th wrap event.
  - T=0 → RUN at the first wrap event.

Optional Feature:
- Macro: STEPDOWN_OCP_RETRY_EN.
- Defined:
  - FAULT loads the retry timer with RETRY_CYC-1 on entry and decrements it each cycle.
  - At 0 with ocp_s=0 → SOFTSTART (duty=0, cnt=0).
  - At 0 with ocp_s=1 → timer reloads and the state stays FAULT.
- Undefined:
  - FAULT is latched until en=0 (then OFF); no retry timer is synthesised.

Decomposition:
- Shared package stepdown_pkg holds:
  - state enum (2-bit encodings as listed in Ports);
  - default constants PERIOD, DMAX, RETRY_CYC.
- One sub-module, stepdown_sync2: 2-flop synchroniser with asynchronous active-low reset, used for ocp.

Test Plan:
1. Reset: CELRSTN low mid-RUN → all outputs 0 and state=OFF immediately, without waiting for a clock edge.
2. Soft start: en=1, duty_tgt=3 →
   - hs_on width is 0 in period 1, then 1/2/3 cycles per period;
   - pgood=1 at the 4th wrap edge;
   - period stays exactly 200 cycles.
3. Clamp: duty_tgt=250 in RUN → hs_on width 180 cycles from the next period; changing duty_tgt mid-period does not alter the current pulse.
4. OCP: ocp pulse in RUN → fault=1 and hs_on=0 within 3 cycles of ocp rising.
   - Without the macro: fault persists until en=0.
   - With the macro: SOFTSTART 1024 cycles after FAULT entry.
5. Retry with ocp held high (macro defined) → FAULT persists across multiple 1024-cycle retry intervals; SOFTSTART entered only after ocp falls.
6. en=0 coincident with ocp rising, and en=0 mid-soft-start → OFF, fault=0, duty=0; hs_on low from the next edge.
